deinterchange_stream: RTL

- Receive side of the lane interchange: takes 16x64-bit beats that were lane-permuted per stage and restores natural lane order, applying the inverse permutation for each stage.
- Stage and beat are tracked internally by a per-frame state machine, not supplied per beat.
- Sits between the interchange output/memory-bank readback and the MMH-MH hashing datapath.
- Valid/ready streaming on both sides, one registered output stage.

---
 rtl/deinterchange_stream_pkg.sv | 46 ++++
 rtl/deinterchange_stream_lane_permute_comb.sv | 27 ++
 rtl/deinterchange_stream.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/deinterchange_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deinterchange_stream_pkg
// Description : Shared widths, stage encodings, FSM state encodings and the
//               lane-index map used by the lane interchange and its inverse.
// Revision    : 1.0 - initial release
// ============================================================================
package deinterchange_stream_pkg;

  localparam int LANES      = 16;
  localparam int LANE_W     = 64;
  localparam int LANE_IDX_W = 4;
  localparam int STAGE_W    = 4;
  localparam int BEAT_W     = 12;

  // Stage encodings of the interchange
  localparam logic [STAGE_W-1:0] STG_ID        = 4'd0;
  localparam logic [STAGE_W-1:0] STG_INNER     = 4'd1;
  localparam logic [STAGE_W-1:0] STG_NIB_SWAP  = 4'd2;
  localparam logic [STAGE_W-1:0] STG_PAIR_SWAP = 4'd3;

  // Frame FSM encodings
  localparam int               STATE_W  = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;

  // Source lane for output lane j at a given stage. Every map is an
  // involution, so the same function serves forward and inverse directions.
  // The inner-group swap of STG_INNER degenerates to identity on this lane
  // grouping, as do all stages beyond STG_PAIR_SWAP.
  function automatic logic [LANE_IDX_W-1:0] lane_src(
    input logic [STAGE_W-1:0]    stage,
    input logic [LANE_IDX_W-1:0] j
  );
    logic [LANE_IDX_W-1:0] r;
    case (stage)
      STG_NIB_SWAP:  r = {j[1:0], j[3:2]};
      STG_PAIR_SWAP: r = {j[2], j[3], j[0], j[1]};
      default:       r = j;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/deinterchange_stream_lane_permute_comb.sv
`default_nettype none
// ============================================================================
// Module      : lane_permute_comb
// Description : Purely combinational stage-selected lane mux. Output lane j
//               takes input lane lane_src(stage, j). Shared with the forward
//               interchange since each stage map is its own inverse.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_permute_comb
  import deinterchange_stream_pkg::*;
(
  input  logic [STAGE_W-1:0]      stage,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic [LANES*LANE_W-1:0] out_data
);

  // One mux per output lane; lane data passes through unmodified
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    localparam logic [LANE_IDX_W-1:0] c_IDX = LANE_IDX_W'(j);
    logic [LANE_IDX_W-1:0] w_src;

    assign w_src = lane_src(stage, c_IDX);
    assign out_data[j*LANE_W +: LANE_W] = in_data[w_src*LANE_W +: LANE_W];
  end

endmodule
`default_nettype wire

// File: rtl/deinterchange_stream.sv
`default_nettype none
// ============================================================================
// Module      : deinterchange_stream
// Description : Receive-side lane de-interchange. Tracks stage/beat per frame
//               with an IDLE/RUN/DRAIN FSM, applies the inverse lane
//               permutation of the current stage and presents each beat
//               through a single valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module deinterchange_stream
  import deinterchange_stream_pkg::*;
#(
  parameter int BEATS_PER_STAGE = 4096,
  parameter int NUM_STAGES      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [STAGE_W-1:0]      out_stage,
  output logic [BEAT_W-1:0]       out_beat,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam logic [BEAT_W-1:0]  c_LAST_BEAT  = BEAT_W'(BEATS_PER_STAGE - 1);
  localparam logic [STAGE_W-1:0] c_LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  logic [STATE_W-1:0]      r_state;
  logic [STATE_W-1:0]      w_state_nxt;
  logic [STAGE_W-1:0]      r_stage_cnt;
  logic [BEAT_W-1:0]       r_beat_cnt;

  logic                    r_out_valid;
  logic [LANES*LANE_W-1:0] r_out_data;
  logic [STAGE_W-1:0]      r_out_stage;
  logic [BEAT_W-1:0]       r_out_beat;
  logic                    r_out_last;
  logic                    r_done;

  logic                    w_in_ready;
  logic                    w_busy;
  logic                    w_accept;
  logic                    w_consume;
  logic                    w_beat_wrap;
  logic                    w_frame_end;
  logic [LANES*LANE_W-1:0] w_perm;

  assign w_accept    = in_valid && w_in_ready;
  assign w_consume   = r_out_valid && out_ready;
  assign w_beat_wrap = (r_beat_cnt == c_LAST_BEAT);
  assign w_frame_end = w_beat_wrap && (r_stage_cnt == c_LAST_STAGE);

  // Inverse permutation of the stage currently being received
  lane_permute_comb u_permute (
    .stage    (r_stage_cnt),
    .in_data  (in_data),
    .out_data (w_perm)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: start only honoured in IDLE; DRAIN waits for the last beat
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start)                     w_state_nxt = ST_RUN;
      ST_RUN:   if (w_accept && w_frame_end)   w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_consume && r_out_last)   w_state_nxt = ST_IDLE;
      default:                                 w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: accept only in RUN and only when the output slot frees up
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = (r_state != ST_IDLE);
    if (r_state == ST_RUN) begin
      w_in_ready = !r_out_valid || out_ready;
    end
  end

  // Stage/beat counters, cleared on start and on the final beat of a frame
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage_cnt <= '0;
      r_beat_cnt  <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_stage_cnt <= '0;
      r_beat_cnt  <= '0;
    end else if (w_accept) begin
      if (w_frame_end) begin
        r_stage_cnt <= '0;
        r_beat_cnt  <= '0;
      end else if (w_beat_wrap) begin
        r_stage_cnt <= r_stage_cnt + 1'b1;
        r_beat_cnt  <= '0;
      end else begin
        r_beat_cnt  <= r_beat_cnt + 1'b1;
      end
    end
  end

  // Output register: reload on accept (even while draining), clear valid on drain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_stage <= '0;
      r_out_beat  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_perm;
      r_out_stage <= r_stage_cnt;
      r_out_beat  <= r_beat_cnt;
      r_out_last  <= w_frame_end;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  // Done pulse follows the edge at which the last beat leaves
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DRAIN) && w_consume && r_out_last;
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = w_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_stage = r_out_stage;
  assign out_beat  = r_out_beat;
  assign out_last  = r_out_last;
  assign done      = r_done;

endmodule
`default_nettype wire
